// File: rtl/diff_encoder.sv
// Streaming per-channel delta encoder: out_data = in_data - prev[in_ch], wrapping mod 2^WIDTH.
// One output register stage; the downstream wrap-around adder restores the samples exactly.
module diff_encoder #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CH_W-1:0]  in_ch,
  input  logic             in_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CH_W-1:0]  out_ch,
  output logic             out_zero,
  output logic [CNT_W-1:0] zero_cnt
);

  // Handshake: a beat moves on a port in any cycle where valid && ready. Valid never
  // depends on ready, and once out_valid is high the out_* fields stay stable until taken.
  localparam logic [CH_W:0] CH_LIMIT = (CH_W+1)'(CHANNELS);

  logic [WIDTH-1:0] prev [CHANNELS];
  logic             accept;
  logic             ch_legal;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] delta;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign ch_legal = ({1'b0, in_ch} < CH_LIMIT);

  always_comb begin
    base = '0;
    if (!(in_first || clear) && ch_legal) base = prev[in_ch];
    delta = in_data - base;
  end

  // The accepted write is placed after the clear so it wins for its own entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) prev[i] <= '0;
    end else begin
      if (clear) begin
        for (int i = 0; i < CHANNELS; i++) prev[i] <= '0;
      end
      if (accept && ch_legal) prev[in_ch] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_zero  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= delta;
      out_ch    <= in_ch;
      out_zero  <= (delta == '0);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_cnt <= '0;
    end else if (out_valid && out_ready && out_zero && (zero_cnt != '1)) begin
      zero_cnt <= zero_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_diff_encoder.sv
// Directed bench for diff_encoder: delta values, stall behaviour, first/clear rules,
// counter saturation (narrow-counter instance) and a wrap-add round trip.
module tb_diff_encoder;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_ch;
  logic        in_first;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_ch;
  logic        out_zero;
  logic [15:0] zero_cnt;

  logic        in_ready_c4;
  logic        out_valid_c4;
  logic [31:0] out_data_c4;
  logic [1:0]  out_ch_c4;
  logic        out_zero_c4;
  logic [3:0]  zero_cnt_c4;

  int vectors = 0;
  int errs    = 0;

  logic [31:0] acc [4];
  bit          need_first [4];
  logic [31:0] recon;
  logic [31:0] d;
  logic [1:0]  ch;
  logic        first;
  logic        clr;

  diff_encoder #(.WIDTH(32), .CHANNELS(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_ch(in_ch), .in_first(in_first),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_zero(out_zero), .zero_cnt(zero_cnt)
  );

  diff_encoder #(.WIDTH(32), .CHANNELS(4), .CNT_W(4)) u_dut_c4 (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_c4), .in_data(in_data),
    .in_ch(in_ch), .in_first(in_first),
    .out_valid(out_valid_c4), .out_ready(out_ready), .out_data(out_data_c4),
    .out_ch(out_ch_c4), .out_zero(out_zero_c4), .zero_cnt(zero_cnt_c4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [31:0] dat, input logic [1:0] c,
                          input logic z);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_data"}, out_data, dat);
    chk({tag, "_ch"}, {30'b0, out_ch}, {30'b0, c});
    chk({tag, "_zero"}, {31'b0, out_zero}, {31'b0, z});
  endtask

  task automatic send(input logic [1:0] c, input logic [31:0] dat, input logic f,
                      input logic cl);
    in_valid = 1'b1;
    in_ch    = c;
    in_data  = dat;
    in_first = f;
    clear    = cl;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_ch = '0;
    in_first = 1'b0; out_ready = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);

    // reset state
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_ch", {30'b0, out_ch}, 32'd0);
    chk("rst_out_zero", {31'b0, out_zero}, 32'd0);
    chk("rst_zero_cnt", {16'b0, zero_cnt}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // 1: ch0 5,7,7,3
    send(2'd0, 32'd5, 1'b0, 1'b0); chk_beat("t1_b0", 32'd5, 2'd0, 1'b0);
    send(2'd0, 32'd7, 1'b0, 1'b0); chk_beat("t1_b1", 32'd2, 2'd0, 1'b0);
    send(2'd0, 32'd7, 1'b0, 1'b0); chk_beat("t1_b2", 32'd0, 2'd0, 1'b1);
    send(2'd0, 32'd3, 1'b0, 1'b0); chk_beat("t1_b3", 32'hFFFF_FFFC, 2'd0, 1'b0);
    chk("t1_zero_cnt", {16'b0, zero_cnt}, 32'd1);
    idle(1);
    chk("t1_drained", {31'b0, out_valid}, 32'd0);
    chk("t1_zero_cnt_c4", {28'b0, zero_cnt_c4}, 32'd1);

    // 2: interleaved channels (ch0 restarts its frame)
    send(2'd0, 32'd10, 1'b1, 1'b0);  chk_beat("t2_b0", 32'd10, 2'd0, 1'b0);
    send(2'd1, 32'd100, 1'b0, 1'b0); chk_beat("t2_b1", 32'd100, 2'd1, 1'b0);
    send(2'd0, 32'd12, 1'b0, 1'b0);  chk_beat("t2_b2", 32'd2, 2'd0, 1'b0);
    send(2'd1, 32'd90, 1'b0, 1'b0);  chk_beat("t2_b3", 32'hFFFF_FFF6, 2'd1, 1'b0);
    idle(1);

    // 3: stall with a beat pending, then release
    out_ready = 1'b0;
    send(2'd0, 32'd20, 1'b0, 1'b0); chk_beat("t3_load", 32'd8, 2'd0, 1'b0);
    in_valid = 1'b1; in_ch = 2'd0; in_data = 32'd25;
    repeat (3) begin
      #1;
      chk("t3_in_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      chk_beat("t3_hold", 32'd8, 2'd0, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk("t3_release_rdy", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk_beat("t3_next", 32'd5, 2'd0, 1'b0);
    chk("t3_zero_cnt", {16'b0, zero_cnt}, 32'd1);
    idle(1);

    // 4: in_first and clear
    send(2'd2, 32'd50, 1'b1, 1'b0); chk_beat("t4_p50", 32'd50, 2'd2, 1'b0);
    send(2'd2, 32'd60, 1'b1, 1'b0); chk_beat("t4_first", 32'd60, 2'd2, 1'b0);
    send(2'd2, 32'd70, 1'b0, 1'b1); chk_beat("t4_clear", 32'd70, 2'd2, 1'b0);
    send(2'd2, 32'd75, 1'b0, 1'b0); chk_beat("t4_ch2", 32'd5, 2'd2, 1'b0);
    send(2'd0, 32'd9, 1'b0, 1'b0);  chk_beat("t4_ch0", 32'd9, 2'd0, 1'b0);
    send(2'd1, 32'd4, 1'b0, 1'b0);  chk_beat("t4_ch1", 32'd4, 2'd1, 1'b0);
    send(2'd3, 32'd0, 1'b0, 1'b0);  chk_beat("t4_ch3", 32'd0, 2'd3, 1'b1);
    idle(1);
    chk("t4_zero_cnt", {16'b0, zero_cnt}, 32'd2);

    // 5: 20 equal samples on ch1 (prev 4): one delta of 29 then 19 zeros
    for (int i = 0; i < 20; i++) send(2'd1, 32'd33, 1'b0, 1'b0);
    chk_beat("t5_last", 32'd0, 2'd1, 1'b1);
    chk("t5_c4_data", out_data_c4, 32'd0);
    idle(1);
    chk("t5_zero_cnt", {16'b0, zero_cnt}, 32'd21);
    chk("t5_sat_c4", {28'b0, zero_cnt_c4}, 32'd15);

    // 6: random round trip through a wrap-add reconstruction, with reset mid-stream
    for (int c = 0; c < 4; c++) begin
      acc[c] = 32'd0;
      need_first[c] = 1'b1;
    end
    for (int i = 0; i < 1000; i++) begin
      if (i == 500) begin
        rst = 1'b1;
        #2;
        chk("t6_async_valid", {31'b0, out_valid}, 32'd0);
        chk("t6_async_cnt", {16'b0, zero_cnt}, 32'd0);
        chk("t6_async_cnt_c4", {28'b0, zero_cnt_c4}, 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
          acc[c] = 32'd0;
          need_first[c] = 1'b1;
        end
        idle(1);
      end
      ch    = 2'($urandom_range(0, 3));
      d     = ($urandom_range(0, 1) == 1) ? $urandom : acc[ch] + $urandom_range(0, 3);
      first = need_first[ch] || ($urandom_range(0, 7) == 0);
      clr   = ($urandom_range(0, 15) == 0);
      send(ch, d, first, clr);
      recon = ((first || clr) ? 32'd0 : acc[ch]) + out_data;
      chk("t6_roundtrip", recon, d);
      if (clr) begin
        for (int c = 0; c < 4; c++) acc[c] = 32'd0;
      end
      acc[ch] = d;
      need_first[ch] = 1'b0;
    end
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
